// File: rtl/hp_clk_pkg.sv
// Shared definitions for the phi1/phi2 phase generator: debug mode encodings,
// generator FSM states and the configuration legality check.
package hp_clk_pkg;

   localparam logic [1:0] MODE_RUN  = 2'b00;
   localparam logic [1:0] MODE_HALT = 2'b01;
   localparam logic [1:0] MODE_STEP = 2'b10;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_HALTED,
      ST_STEP
   } gen_state_e;

   // Phase positions must be distinct and inside a period of at least two cycles.
   function automatic logic cfg_valid(input logic [31:0] div,
                                      input logic [31:0] p1,
                                      input logic [31:0] p2);
      return (div >= 32'd2) && (p1 < div) && (p2 < div) && (p1 != p2);
   endfunction

endpackage

// File: rtl/hp_tstate_ring.sv
// One-hot T-state ring: rotates one position per advance, or jumps to a fixed
// index when a resync is requested on the advancing edge.
module hp_tstate_ring
   import hp_clk_pkg::*;
#(
   parameter int NUM_T      = 4,
   parameter int RESYNC_IDX = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             advance_i,
   input  logic             resync_i,
   output logic [NUM_T-1:0] ring_o
);

   localparam logic [NUM_T-1:0] RING_RESET  = NUM_T'(1);
   localparam logic [NUM_T-1:0] RESYNC_VEC  = NUM_T'(1) << RESYNC_IDX;

   logic [NUM_T-1:0] ring_q;
   logic [NUM_T-1:0] ring_d;

   always_comb begin
      ring_d = ring_q;
      if (advance_i) begin
         if (resync_i) begin
            ring_d = RESYNC_VEC;
         end else begin
            ring_d = {ring_q[NUM_T-2:0], ring_q[NUM_T-1]};
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ring_q <= RING_RESET;
      end else begin
         ring_q <= ring_d;
      end
   end

   assign ring_o = ring_q;

endmodule

// File: rtl/hp_phase_gen.sv
// Programmable two-phase non-overlapping clock generator for the calculator
// core, with T-state ring, shadowed runtime config and halt/single-step control.
module hp_phase_gen
   import hp_clk_pkg::*;
#(
   parameter int DIV_W        = 4,
   parameter int NUM_T        = 4,
   parameter int DEF_DIV      = 8,
   parameter int DEF_PHI1_POS = 5,
   parameter int DEF_PHI2_POS = 7,
   parameter int RESYNC_IDX   = 2,
   parameter int CYC_W        = 16
) (
   input  logic             osc_in,
   input  logic             cdiv_rst_n,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic [DIV_W-1:0] cfg_phi1_pos,
   input  logic [DIV_W-1:0] cfg_phi2_pos,
   input  logic             cfg_load,
   input  logic [1:0]       mode,
   input  logic             step_req,
   input  logic             resync,
   output logic             phi1_out,
   output logic             phi2_out,
   output logic [NUM_T-1:0] t_state,
   output logic [CYC_W-1:0] cyc_cnt,
   output logic             halted,
   output logic             step_done,
   output logic             cfg_err
);

   localparam logic [DIV_W-1:0] DEF_DIV_V  = DIV_W'(DEF_DIV);
   localparam logic [DIV_W-1:0] DEF_PHI1_V = DIV_W'(DEF_PHI1_POS);
   localparam logic [DIV_W-1:0] DEF_PHI2_V = DIV_W'(DEF_PHI2_POS);

   gen_state_e       state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] p1_pos_q, p1_pos_d;
   logic [DIV_W-1:0] p2_pos_q, p2_pos_d;
   logic [DIV_W-1:0] sh_div_q, sh_div_d;
   logic [DIV_W-1:0] sh_p1_q, sh_p1_d;
   logic [DIV_W-1:0] sh_p2_q, sh_p2_d;
   logic             sh_vld_q, sh_vld_d;
   logic             phi1r_q, phi1r_d;
   logic             phi2r_q, phi2r_d;
   logic [CYC_W-1:0] cyc_q, cyc_d;
   logic             step_done_q, step_done_d;
   logic             cfg_err_q, cfg_err_d;

   logic running;
   logic wrap;
   logic commit;
   logic load_ok;

   assign running = (state_q != ST_HALTED);
   assign wrap    = running && (cnt_q == (div_q - DIV_W'(1)));
   assign commit  = sh_vld_q && (wrap || (state_q == ST_HALTED));
   assign load_ok = cfg_valid(32'(cfg_div), 32'(cfg_phi1_pos), 32'(cfg_phi2_pos));

   // Counter, phase strobes, shadow config and period count.
   always_comb begin
      cnt_d    = cnt_q;
      div_d    = div_q;
      p1_pos_d = p1_pos_q;
      p2_pos_d = p2_pos_q;
      sh_div_d = sh_div_q;
      sh_p1_d  = sh_p1_q;
      sh_p2_d  = sh_p2_q;
      sh_vld_d = sh_vld_q;
      cfg_err_d = cfg_err_q;
      phi1r_d  = running && (cnt_q == p1_pos_q);
      phi2r_d  = running && (cnt_q == p2_pos_q);
      cyc_d    = cyc_q + CYC_W'(wrap);

      if (wrap) begin
         cnt_d = '0;
      end else if (running) begin
         cnt_d = cnt_q + DIV_W'(1);
      end

      // A pending shadow is applied before the next period starts at cnt=0.
      if (commit) begin
         div_d    = sh_div_q;
         p1_pos_d = sh_p1_q;
         p2_pos_d = sh_p2_q;
         sh_vld_d = 1'b0;
      end

      if (cfg_load) begin
         cfg_err_d = !load_ok;
         if (load_ok) begin
            sh_div_d = cfg_div;
            sh_p1_d  = cfg_phi1_pos;
            sh_p2_d  = cfg_phi2_pos;
            sh_vld_d = 1'b1;
         end
      end
   end

   // Debug FSM: halts only at period boundaries, single step runs one period.
   always_comb begin
      state_d     = state_q;
      step_done_d = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (wrap && (mode != MODE_RUN)) begin
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            if (mode == MODE_RUN) begin
               state_d = ST_RUN;
            end else if ((mode == MODE_STEP) && step_req) begin
               state_d = ST_STEP;
            end
         end
         ST_STEP: begin
            if (wrap) begin
               state_d     = ST_HALTED;
               step_done_d = 1'b1;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge osc_in or negedge cdiv_rst_n) begin
      if (!cdiv_rst_n) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         div_q       <= DEF_DIV_V;
         p1_pos_q    <= DEF_PHI1_V;
         p2_pos_q    <= DEF_PHI2_V;
         sh_div_q    <= DEF_DIV_V;
         sh_p1_q     <= DEF_PHI1_V;
         sh_p2_q     <= DEF_PHI2_V;
         sh_vld_q    <= 1'b0;
         phi1r_q     <= 1'b0;
         phi2r_q     <= 1'b0;
         cyc_q       <= '0;
         step_done_q <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         div_q       <= div_d;
         p1_pos_q    <= p1_pos_d;
         p2_pos_q    <= p2_pos_d;
         sh_div_q    <= sh_div_d;
         sh_p1_q     <= sh_p1_d;
         sh_p2_q     <= sh_p2_d;
         sh_vld_q    <= sh_vld_d;
         phi1r_q     <= phi1r_d;
         phi2r_q     <= phi2r_d;
         cyc_q       <= cyc_d;
         step_done_q <= step_done_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   hp_tstate_ring #(
      .NUM_T      (NUM_T),
      .RESYNC_IDX (RESYNC_IDX)
   ) u_ring (
      .clk_i     (osc_in),
      .rst_ni    (cdiv_rst_n),
      .advance_i (wrap),
      .resync_i  (resync),
      .ring_o    (t_state)
   );

   assign phi1_out  = ~phi1r_q;
   assign phi2_out  = ~phi2r_q;
   assign cyc_cnt   = cyc_q;
   assign halted    = (state_q == ST_HALTED);
   assign step_done = step_done_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: doc/hp_phase_gen.md
Name: hp_phase_gen

Overview:
Parametrised successor to the fixed divide-by-8 phi1/phi2 generator inside the core wrapper. Derives the two-phase, non-overlapping calculator clocks and the one-hot T-state ring from osc_in. Adds runtime-programmable period and phase positions, an N-state ring with display-driven resync, and halt/single-step debug modes driven from the Caravel LA. Its outputs feed the phi1/phi2 select mux in front of the ARC, CTC and ROM instances.

Parameters:
DIV_W, 4, width of divider counter and of config fields
NUM_T, 4, number of T-states in one-hot ring
DEF_DIV, 8, reset period in osc_in cycles
DEF_PHI1_POS, 5, reset counter value that triggers phi1
DEF_PHI2_POS, 7, reset counter value that triggers phi2
RESYNC_IDX, 2, ring index forced on resync (0-based)
CYC_W, 16, width of completed-period counter

Ports:
osc_in  in  1  oscillator clock, all logic on posedge
cdiv_rst_n  in  1  asynchronous active-low reset
cfg_div  in  DIV_W  requested period N
cfg_phi1_pos  in  DIV_W  requested phi1 trigger count
cfg_phi2_pos  in  DIV_W  requested phi2 trigger count
cfg_load  in  1  single-cycle pulse: capture cfg_* into shadow
mode  in  2  00 RUN, 01 HALT, 10 STEP, 11 treated as HALT
step_req  in  1  single-cycle pulse: one period while halted
resync  in  1  display sync request (DD[1]&DD[3] at top level)
phi1_out  out  1  active-low phi1
phi2_out  out  1  active-low phi2
t_state  out  NUM_T  one-hot T-state ring
cyc_cnt  out  CYC_W  completed periods, wraps
halted  out  1  generator stopped at period boundary
step_done  out  1  one-cycle pulse at end of stepped period
cfg_err  out  1  sticky: last cfg_load rejected

Behaviour:
- Reset (async, cdiv_rst_n=0):
  - cnt=0; active div/phi1/phi2 = DEF_* values; shadow invalid.
  - t_state=bit0; phi1_out=phi2_out=1; cyc_cnt=0; halted=0; step_done=0; cfg_err=0.
- Counter: cnt runs 0..div-1. "Wrap" means a running edge with cnt==div-1; cnt returns to 0 on that edge.
- Phases: phi1r is registered as (cnt==phi1_pos) while running, so it is high for exactly one osc cycle, one edge after the match. phi1_out = ~phi1r. phi2 uses the same rule.
- When not running, phi1r and phi2r are 0, so both outputs are 1 (inactive).
- T ring, on each wrap:
  - resync=1 at that edge: force t_state to one-hot RESYNC_IDX.
  - otherwise: rotate so bit i moves to bit i+1 and bit NUM_T-1 moves to bit 0.
- cyc_cnt increments on each wrap, modulo 2^CYC_W.
- cfg_load:
  - Valid when 2<=cfg_div, cfg_phi1_pos<cfg_div, cfg_phi2_pos<cfg_div, and cfg_phi1_pos!=cfg_phi2_pos.
  - Valid: latch into shadow, clear cfg_err, commit at next wrap. The new period starts at cnt=0.
  - Invalid: discard, set cfg_err, keep the existing shadow.
  - A second load before commit overwrites the shadow.
  - Commit also happens on the halted-state edge, so a config load works while halted.
- Modes, as a three-state FSM (RUN, HALTED, STEP):
  - RUN -> HALTED: mode!=RUN sampled at a wrap. The current period always completes; halted=1 from the next edge.
  - HALTED -> RUN: mode==RUN; counting resumes on the next edge.
  - HALTED -> STEP: mode==STEP and step_req=1. Runs exactly div cycles, then returns to HALTED with step_done=1 for one cycle at the wrap edge.
  - step_req is ignored in RUN and during STEP.
  - mode changes during STEP take effect only at its wrap.
- Simultaneous events at one wrap: resync, config commit and halt all apply on the same edge. Commit applies before the new period; the ring uses resync.
- Reset mid-period or mid-step: immediate return to reset values; no step_done.

Decomposition:
- Package hp_clk_pkg:
  - mode encodings MODE_RUN, MODE_HALT, MODE_STEP;
  - FSM state enum;
  - function cfg_valid(div, p1, p2).
- Sub-module hp_tstate_ring (NUM_T, RESYNC_IDX): one-hot ring with advance and resync inputs.
- Top holds the counter, phase registers, shadow config and FSM.

Test Plan:
- Reset release, defaults, mode=RUN:
  - phi1_out low one cycle, then phi2_out low one cycle, 2 cycles later; period 8.
  - t_state sequence 0001→0010→0100→1000→0001 every 8 cycles; cyc_cnt=4 after 32 cycles.
- cfg_load div=12, p1=3, p2=9 mid-period:
  - current period stays 8; following periods are 12.
  - phi1/phi2 lows are 6 cycles apart; cfg_err=0.
- cfg_load div=6, p1=6, p2=2:
  - cfg_err=1; period stays 8.
  - a following valid load clears cfg_err.
- resync held high across one wrap with t_state=0001: next t_state=0100, then rotation continues from there.
- mode=HALT mid-period:
  - finishes to cnt=7; halted=1; phi outputs held 1.
  - step_req: exactly 8 cycles with one phi1 and one phi2 pulse, step_done pulse, cyc_cnt+1, halted again.
- Assert cdiv_rst_n low during STEP at cnt=4:
  - outputs return to reset values immediately; no step_done.
  - after release, resumes in RUN (mode=RUN).
